// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard/stall requests from id/exe/mem and the
// stall, flush and performance outputs returned by the controller.
interface pipe_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 rs1_re_i;
  logic [4:0]           rs1_raddr_i;
  logic                 rs2_re_i;
  logic [4:0]           rs2_raddr_i;
  logic                 inst_is_load_i;
  logic [4:0]           rd_i;
  logic                 stallreq_exe_i;
  logic                 stallreq_mem_i;
  logic                 jump_flag_i;
  logic [5:0]           stall_o;
  logic                 flush_jump_o;
  logic                 state_o;
  logic [CNT_WIDTH-1:0] stall_cnt_o;
  logic [CNT_WIDTH-1:0] bubble_cnt_o;
  logic [CNT_WIDTH-1:0] flush_cnt_o;
  logic                 wdog_o;

  modport master (
    output rs1_re_i, rs1_raddr_i, rs2_re_i, rs2_raddr_i,
    output inst_is_load_i, rd_i, stallreq_exe_i, stallreq_mem_i, jump_flag_i,
    input  stall_o, flush_jump_o, state_o,
    input  stall_cnt_o, bubble_cnt_o, flush_cnt_o, wdog_o
  );

  modport slave (
    input  rs1_re_i, rs1_raddr_i, rs2_re_i, rs2_raddr_i,
    input  inst_is_load_i, rd_i, stallreq_exe_i, stallreq_mem_i, jump_flag_i,
    output stall_o, flush_jump_o, state_o,
    output stall_cnt_o, bubble_cnt_o, flush_cnt_o, wdog_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: stall priority, multi-cycle jump flush,
// stall watchdog and saturating performance counters.
module pipe_ctrl #(
  parameter int FLUSH_LEN  = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int WDOG_LIMIT = 256
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pipe_ctrl_if.slave    bus
);

  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int RW = $clog2(WDOG_LIMIT + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_LEN - 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(WDOG_LIMIT);
  localparam logic [RW-1:0] RUN_TRIP   = RW'(WDOG_LIMIT - 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [FW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] run_reg, run_next;
  logic          wdog_reg, wdog_next;

  logic       load_use;
  logic       frozen;
  logic [5:0] stall;
  logic       flush;
  logic [2:0] cnt_inc;

  assign load_use = bus.inst_is_load_i && (bus.rd_i != 5'd0) &&
                    ((bus.rs1_re_i && (bus.rs1_raddr_i == bus.rd_i)) ||
                     (bus.rs2_re_i && (bus.rs2_raddr_i == bus.rd_i)));

  assign frozen = bus.stallreq_mem_i || bus.stallreq_exe_i;

  // Output priority; the jump/flush case outranks load-use because the
  // instruction that would have caused the bubble is being killed anyway.
  always_comb begin
    stall   = 6'b000000;
    flush   = 1'b0;
    cnt_inc = 3'b000;
    if (bus.stallreq_mem_i) begin
      stall = 6'b011111;
    end else if (bus.stallreq_exe_i) begin
      stall = 6'b001111;
    end else if (bus.jump_flag_i || (state_reg == ST_FLUSH)) begin
      flush = 1'b1;
    end else if (load_use) begin
      stall = 6'b000111;
    end
    cnt_inc[0] = stall[0];
    cnt_inc[1] = !frozen && !flush && load_use;
    cnt_inc[2] = !frozen && bus.jump_flag_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Flush sequencer: a frozen cycle neither counts down nor accepts a jump.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_RUN: begin
        if (!frozen && bus.jump_flag_i && (FLUSH_LEN > 1)) begin
          state_next = ST_FLUSH;
          cnt_next   = FLUSH_INIT;
        end
      end
      ST_FLUSH: begin
        if (!frozen) begin
          if (bus.jump_flag_i) begin
            cnt_next = FLUSH_INIT;
          end else if (cnt_reg == FW'(1)) begin
            cnt_next   = '0;
            state_next = ST_RUN;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Watchdog: consecutive pc-stall run length, trip is sticky until reset.
  always_comb begin
    run_next  = run_reg;
    wdog_next = wdog_reg;
    if (stall[0]) begin
      if (run_reg != RUN_MAX) begin
        run_next = run_reg + 1'b1;
      end
      if (run_reg >= RUN_TRIP) begin
        wdog_next = 1'b1;
      end
    end else begin
      run_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_reg  <= '0;
      wdog_reg <= 1'b0;
    end else begin
      run_reg  <= run_next;
      wdog_reg <= wdog_next;
    end
  end

  logic [3*CNT_WIDTH-1:0] perf_flat;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_perf
      logic [CNT_WIDTH-1:0] perf_reg;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          perf_reg <= '0;
        end else if (cnt_inc[gi] && (perf_reg != {CNT_WIDTH{1'b1}})) begin
          perf_reg <= perf_reg + 1'b1;
        end
      end
      assign perf_flat[gi*CNT_WIDTH +: CNT_WIDTH] = perf_reg;
    end
  endgenerate

  assign bus.stall_o      = stall;
  assign bus.flush_jump_o = flush;
  assign bus.state_o      = (state_reg == ST_FLUSH);
  assign bus.stall_cnt_o  = perf_flat[0*CNT_WIDTH +: CNT_WIDTH];
  assign bus.bubble_cnt_o = perf_flat[1*CNT_WIDTH +: CNT_WIDTH];
  assign bus.flush_cnt_o  = perf_flat[2*CNT_WIDTH +: CNT_WIDTH];
  assign bus.wdog_o       = wdog_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked each
// cycle against a remaining-flush-cycles / integer-counter reference model.
module tb_pipe_ctrl;

  localparam int FLUSH_LEN  = 2;
  localparam int CNT_WIDTH  = 8;
  localparam int WDOG_LIMIT = 256;
  localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_WIDTH(CNT_WIDTH)) dif ();

  pipe_ctrl #(
    .FLUSH_LEN (FLUSH_LEN),
    .CNT_WIDTH (CNT_WIDTH),
    .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (dif.slave)
  );

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_rem = 0;
  int m_stall = 0;
  int m_bubble = 0;
  int m_flush = 0;
  int m_run = 0;
  bit m_wdog = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    dif.rs1_re_i       = 1'b0;
    dif.rs1_raddr_i    = 5'd0;
    dif.rs2_re_i       = 1'b0;
    dif.rs2_raddr_i    = 5'd0;
    dif.inst_is_load_i = 1'b0;
    dif.rd_i           = 5'd0;
    dif.stallreq_exe_i = 1'b0;
    dif.stallreq_mem_i = 1'b0;
    dif.jump_flag_i    = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  // One clock: check outputs at negedge, then advance the model to the next edge.
  task automatic cycle();
    logic [5:0] es;
    bit ef, lu, frz, flushing;
    @(negedge clk);
    lu = dif.inst_is_load_i && (dif.rd_i != 0) &&
         ((dif.rs1_re_i && dif.rs1_raddr_i == dif.rd_i) ||
          (dif.rs2_re_i && dif.rs2_raddr_i == dif.rd_i));
    frz = dif.stallreq_mem_i || dif.stallreq_exe_i;
    flushing = dif.jump_flag_i || (m_rem > 0);
    es = 6'b0;
    ef = 1'b0;
    if (dif.stallreq_mem_i)      es = 6'b011111;
    else if (dif.stallreq_exe_i) es = 6'b001111;
    else if (flushing)           ef = 1'b1;
    else if (lu)                 es = 6'b000111;

    check("stall_o", 32'(dif.stall_o), 32'(es));
    check("flush_jump_o", 32'(dif.flush_jump_o), 32'(ef));
    check("state_o", 32'(dif.state_o), 32'(m_rem > 0));
    check("stall_cnt_o", 32'(dif.stall_cnt_o), 32'(m_stall));
    check("bubble_cnt_o", 32'(dif.bubble_cnt_o), 32'(m_bubble));
    check("flush_cnt_o", 32'(dif.flush_cnt_o), 32'(m_flush));
    check("wdog_o", 32'(dif.wdog_o), 32'(m_wdog));
    n_vec++;

    if (rst) begin
      m_rem = 0; m_stall = 0; m_bubble = 0; m_flush = 0; m_run = 0; m_wdog = 1'b0;
    end else begin
      if (es[0]) m_stall = sat(m_stall + 1);
      if (!frz && !flushing && lu) m_bubble = sat(m_bubble + 1);
      if (!frz && dif.jump_flag_i) begin
        m_flush = sat(m_flush + 1);
        m_rem = FLUSH_LEN - 1;
      end else if (!frz && m_rem > 0) begin
        m_rem--;
      end
      if (es[0]) begin
        m_run++;
        if (m_run >= WDOG_LIMIT) m_wdog = 1'b1;
      end else begin
        m_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle();
    @(posedge clk);
    #1;
    do_reset();
    check("reset_stall_cnt", 32'(dif.stall_cnt_o), 32'd0);
    check("reset_wdog", 32'(dif.wdog_o), 32'd0);

    // Load x5 followed by reader of x5: one bubble
    dif.inst_is_load_i = 1'b1; dif.rd_i = 5'd5; dif.rs1_re_i = 1'b1; dif.rs1_raddr_i = 5'd5;
    cycle();
    idle();
    cycle();
    check("bubble_after_load_use", 32'(dif.bubble_cnt_o), 32'd1);

    // Load to x0 read back as x0: no hazard
    dif.inst_is_load_i = 1'b1; dif.rd_i = 5'd0; dif.rs2_re_i = 1'b1; dif.rs2_raddr_i = 5'd0;
    cycle();
    idle();
    check("bubble_x0", 32'(dif.bubble_cnt_o), 32'd1);

    // Single-cycle jump: two flush cycles
    do_reset();
    dif.jump_flag_i = 1'b1;
    cycle();
    dif.jump_flag_i = 1'b0;
    check("state_flush_2nd", 32'(dif.state_o), 32'd1);
    cycle();
    cycle();
    check("flush_cnt_one_jump", 32'(dif.flush_cnt_o), 32'd1);
    check("state_back_run", 32'(dif.state_o), 32'd0);

    // Jump held under a 3-cycle mem wait, accepted once unfrozen
    do_reset();
    dif.jump_flag_i = 1'b1; dif.stallreq_mem_i = 1'b1;
    repeat (3) cycle();
    check("flush_cnt_frozen", 32'(dif.flush_cnt_o), 32'd0);
    dif.stallreq_mem_i = 1'b0;
    cycle();
    dif.jump_flag_i = 1'b0;
    cycle();
    cycle();
    check("flush_cnt_after_mem", 32'(dif.flush_cnt_o), 32'd1);

    // Jump and load-use together: jump wins, no bubble
    do_reset();
    dif.jump_flag_i = 1'b1; dif.inst_is_load_i = 1'b1; dif.rd_i = 5'd7;
    dif.rs2_re_i = 1'b1; dif.rs2_raddr_i = 5'd7;
    cycle();
    idle();
    cycle();
    check("bubble_jump_collision", 32'(dif.bubble_cnt_o), 32'd0);

    // Random traffic, including rare mid-sequence resets
    for (int i = 0; i < 3000; i++) begin
      dif.stallreq_mem_i = ($urandom_range(0, 11) == 0);
      dif.stallreq_exe_i = ($urandom_range(0, 9) == 0);
      dif.jump_flag_i    = ($urandom_range(0, 4) == 0);
      dif.inst_is_load_i = $urandom_range(0, 1) == 1;
      dif.rd_i           = 5'($urandom_range(0, 3));
      dif.rs1_re_i       = $urandom_range(0, 1) == 1;
      dif.rs1_raddr_i    = 5'($urandom_range(0, 3));
      dif.rs2_re_i       = $urandom_range(0, 1) == 1;
      dif.rs2_raddr_i    = 5'($urandom_range(0, 3));
      rst                = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    // Watchdog: exe stall held WDOG_LIMIT cycles, stall_cnt saturates too
    do_reset();
    dif.stallreq_exe_i = 1'b1;
    repeat (WDOG_LIMIT - 1) cycle();
    check("wdog_before_limit", 32'(dif.wdog_o), 32'd0);
    cycle();
    check("wdog_at_limit", 32'(dif.wdog_o), 32'd1);
    check("stall_cnt_saturated", 32'(dif.stall_cnt_o), 32'(CNT_MAX));
    dif.stallreq_exe_i = 1'b0;
    repeat (4) cycle();
    check("wdog_sticky", 32'(dif.wdog_o), 32'd1);
    do_reset();
    check("wdog_cleared", 32'(dif.wdog_o), 32'd0);
    check("stall_cnt_cleared", 32'(dif.stall_cnt_o), 32'd0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
